// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bank crossbar.
// Contents: requester indices, default geometry with its derived widths, a helper
// that derives the bank-select width, and the per-requester response tag.
package dmem_pkg;

  localparam int unsigned MST_CORE   = 0;
  localparam int unsigned MST_FABRIC = 1;
  localparam int unsigned NUM_MST    = 2;

  // Wide enough for the largest supported bank count (8).
  localparam int unsigned BANK_IDX_W = 3;

  localparam int unsigned DEF_NUM_BANKS = 4;
  localparam int unsigned DEF_BANK_AW   = 8;

  // log2 of a power-of-two bank count in 1..8.
  function automatic int unsigned calc_bs(input int unsigned num_banks);
    int unsigned bs;
    bs = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((32'd1 << i) < num_banks) bs = i + 1;
    end
    return bs;
  endfunction

  localparam int unsigned BS    = calc_bs(DEF_NUM_BANKS);
  localparam int unsigned ROW_W = DEF_BANK_AW;

  typedef struct packed {
    logic                  pend;
    logic [BANK_IDX_W-1:0] bank;
    logic                  is_read;
    logic                  err;
  } rsp_tag_t;

endpackage

// File: rtl/dmem_bank_arb.sv
// Two-requester round-robin arbiter for one SRAM bank.
// Ports: clk, reset (async, active high), req_i[1:0] in-range requests aimed at this
// bank, gnt_o[1:0] combinational one-hot grant.
module dmem_bank_arb
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0: core wins the next conflict, 1: fabric wins it.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o[MST_CORE]   = req_i[MST_CORE] & (~req_i[MST_FABRIC] | ~prio_q);
    gnt_o[MST_FABRIC] = req_i[MST_FABRIC] & (~req_i[MST_CORE] | prio_q);
    prio_d = prio_q;
    // After a conflict the loser gets priority; otherwise priority is left alone.
    if (&req_i) prio_d = ~prio_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_bank_xbar.sv
// Data-memory crossbar: core (requester 0) and eFPGA fabric (requester 1) onto
// NUM_BANKS word-interleaved sram_1rw1r_32_256_8_sky130 macros (port 0).
// Ports: clk, reset (async, active high); OBI-style m_* request/grant/response per
// requester (flat vectors, requester 0 in the low slice); sram_* per-bank port-0 drive
// and dout0 return (bank 0 in the low slice). Grants are combinational; every granted
// access, including out-of-range errors, responds exactly one cycle later.
module dmem_bank_xbar
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_AW   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   m_req_i,
  output logic [1:0]                   m_gnt_o,
  output logic [1:0]                   m_rvalid_o,
  input  logic [1:0]                   m_we_i,
  input  logic [7:0]                   m_be_i,
  input  logic [63:0]                  m_addr_i,
  input  logic [63:0]                  m_wdata_i,
  output logic [63:0]                  m_rdata_o,
  output logic [1:0]                   m_err_o,
  output logic [NUM_BANKS-1:0]         sram_csb_o,
  output logic [NUM_BANKS-1:0]         sram_web_o,
  output logic [NUM_BANKS*4-1:0]       sram_wmask_o,
  output logic [NUM_BANKS*BANK_AW-1:0] sram_addr_o,
  output logic [NUM_BANKS*32-1:0]      sram_din_o,
  input  logic [NUM_BANKS*32-1:0]      sram_dout_i
);

  localparam int unsigned Bs     = calc_bs(NUM_BANKS);
  localparam int unsigned HighLo = 2 + Bs + BANK_AW;

  logic [BANK_IDX_W-1:0] bank_m [NUM_MST];
  logic [BANK_AW-1:0]    row_m  [NUM_MST];
  logic [NUM_MST-1:0]    oor;
  logic [1:0]            bank_req [NUM_BANKS];
  logic [1:0]            bank_gnt [NUM_BANKS];
  rsp_tag_t              tag_d [NUM_MST];
  rsp_tag_t              tag_q [NUM_MST];

  // Address decode and per-bank request vectors. Reset masks every request.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) bank_req[b] = '0;
    for (int unsigned m = 0; m < NUM_MST; m++) begin
      bank_m[m] = BANK_IDX_W'((m_addr_i[32*m +: 32] >> 2) & (NUM_BANKS - 1));
      row_m[m]  = BANK_AW'(m_addr_i[32*m +: 32] >> (2 + Bs));
      oor[m]    = (m_addr_i[32*m +: 32] >> HighLo) != 32'd0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        bank_req[b][m] = ~reset & m_req_i[m] & ~oor[m] & (bank_m[m] == BANK_IDX_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dmem_bank_arb u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  // Out-of-range requests are granted without touching any bank.
  always_comb begin
    m_gnt_o = '0;
    for (int unsigned m = 0; m < NUM_MST; m++) begin
      m_gnt_o[m] = ~reset & m_req_i[m] & oor[m];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        m_gnt_o[m] = m_gnt_o[m] | bank_gnt[b][m];
      end
    end
  end

  // SRAM fan-out; bank grants are one-hot so at most one requester drives a bank.
  always_comb begin
    sram_csb_o   = '1;
    sram_web_o   = '1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned m = 0; m < NUM_MST; m++) begin
        if (bank_gnt[b][m]) begin
          sram_csb_o[b]                       = 1'b0;
          sram_web_o[b]                       = ~m_we_i[m];
          sram_wmask_o[4*b +: 4]              = m_be_i[4*m +: 4];
          sram_addr_o[BANK_AW*b +: BANK_AW]   = row_m[m];
          sram_din_o[32*b +: 32]              = m_wdata_i[32*m +: 32];
        end
      end
    end
  end

  // Response tags: one outstanding response per requester, reloaded every cycle so a
  // new grant can overlap delivery of the previous response.
  always_comb begin
    for (int unsigned m = 0; m < NUM_MST; m++) begin
      tag_d[m].pend    = m_gnt_o[m];
      tag_d[m].bank    = bank_m[m];
      tag_d[m].is_read = ~m_we_i[m];
      tag_d[m].err     = oor[m];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned m = 0; m < NUM_MST; m++) tag_q[m] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    for (int unsigned m = 0; m < NUM_MST; m++) begin
      m_rvalid_o[m] = tag_q[m].pend;
      m_err_o[m]    = tag_q[m].pend & tag_q[m].err;
      if (tag_q[m].pend && tag_q[m].is_read && !tag_q[m].err) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (tag_q[m].bank == BANK_IDX_W'(b)) m_rdata_o[32*m +: 32] = sram_dout_i[32*b +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bank_xbar.sv
// Self-checking bench for dmem_bank_xbar (NUM_BANKS=4, BANK_AW=8). The reference is a
// flat word-addressed memory plus a per-bank "who wins the next tie" bit; a behavioural
// SRAM model (1-cycle read latency, masked writes) sits on the bank ports.
module tb_dmem_bank_xbar;

  localparam int unsigned NB       = 4;
  localparam int unsigned AW       = 8;
  localparam int unsigned Rows     = 256;
  localparam int unsigned Words    = NB * Rows;
  localparam logic [31:0] ByteSpan = 32'(Words * 4);

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        m_req, m_gnt, m_rvalid, m_we, m_err;
  logic [7:0]        m_be;
  logic [63:0]       m_addr, m_wdata, m_rdata;
  logic [NB-1:0]     csb, web;
  logic [NB*4-1:0]   wmask;
  logic [NB*AW-1:0]  saddr;
  logic [NB*32-1:0]  din, dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sram_mem [NB][Rows];
  logic [31:0] sram_q [NB];
  logic [31:0] ref_mem [Words];
  logic        mprio [NB];

  always #5 clk = ~clk;

  dmem_bank_xbar #(.NUM_BANKS(NB), .BANK_AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req_i      (m_req),
    .m_gnt_o      (m_gnt),
    .m_rvalid_o   (m_rvalid),
    .m_we_i       (m_we),
    .m_be_i       (m_be),
    .m_addr_i     (m_addr),
    .m_wdata_i    (m_wdata),
    .m_rdata_o    (m_rdata),
    .m_err_o      (m_err),
    .sram_csb_o   (csb),
    .sram_web_o   (web),
    .sram_wmask_o (wmask),
    .sram_addr_o  (saddr),
    .sram_din_o   (din),
    .sram_dout_i  (dout)
  );

  // SRAM port-0 model.
  logic [31:0] wtmp;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!csb[b]) begin
        if (!web[b]) begin
          wtmp = sram_mem[b][saddr[AW*b +: AW]];
          for (int k = 0; k < 4; k++) if (wmask[4*b+k]) wtmp[8*k +: 8] = din[32*b+8*k +: 8];
          sram_mem[b][saddr[AW*b +: AW]] = wtmp;
        end else begin
          sram_q[b] <= sram_mem[b][saddr[AW*b +: AW]];
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_dout
    assign dout[32*b +: 32] = sram_q[b];
  end

  function automatic logic [31:0] seed_word(input int unsigned w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic set_req(input int m, input logic r, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    m_req[m]          = r;
    m_we[m]           = we;
    m_be[4*m +: 4]    = be;
    m_addr[32*m +: 32] = a;
    m_wdata[32*m +: 32] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int b = 0; b < NB; b++) mprio[b] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    #1;
    n_cmp++;
    if (m_gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", m_gnt); end
    n_cmp++;
    if (m_rvalid !== 2'b00 || m_err !== 2'b00 || m_rdata !== 64'h0) begin
      n_err++; $display("FAIL rst_rsp: rvalid %b err %b rdata %h want 0", m_rvalid, m_err, m_rdata);
    end
    n_cmp++;
    if (csb !== 4'hF || web !== 4'hF) begin
      n_err++; $display("FAIL rst_bank: csb %b web %b want 1111/1111", csb, web);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (m_gnt !== 2'b11) begin n_err++; $display("FAIL rst_first_gnt: got %b want 11", m_gnt); end
    m_req = 2'b00;
    for (int b = 0; b < NB; b++) mprio[b] = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (m_rvalid !== 2'b00) begin n_err++; $display("FAIL rst_no_rsp: got %b want 00", m_rvalid); end
  endtask

  task automatic test_single_read();
    logic [31:0] exp;
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    exp = ref_mem[4];
    #4;
    n_cmp++;
    if (m_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", m_gnt); end
    n_cmp++;
    if (csb !== 4'b1110 || web[0] !== 1'b1 || saddr[AW-1:0] !== 8'd1) begin
      n_err++; $display("FAIL single_bank: csb %b web0 %b row %h want 1110/1/01", csb, web[0],
                        saddr[AW-1:0]);
    end
    @(posedge clk); #1;
    m_req = 2'b00;
    n_cmp++;
    if (m_rvalid !== 2'b01 || m_err !== 2'b00 || m_rdata[31:0] !== exp) begin
      n_err++; $display("FAIL single_rsp: rvalid %b err %b rdata %h want 01/00/%h", m_rvalid,
                        m_err, m_rdata[31:0], exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_parallel();
    logic [31:0] exp_f, wd;
    wd = 32'hA5C3_1E77;
    set_req(0, 1'b1, 1'b1, 4'b0101, 32'h0, wd);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    exp_f = ref_mem[1];
    #4;
    n_cmp++;
    if (m_gnt !== 2'b11) begin n_err++; $display("FAIL par_gnt: got %b want 11", m_gnt); end
    n_cmp++;
    if (csb !== 4'b1100 || web[1:0] !== 2'b10 || wmask[3:0] !== 4'b0101 || din[31:0] !== wd) begin
      n_err++; $display("FAIL par_bank: csb %b web %b wmask0 %b din0 %h want 1100/10/0101/%h",
                        csb, web[1:0], wmask[3:0], din[31:0], wd);
    end
    ref_mem[0][7:0]   = wd[7:0];
    ref_mem[0][23:16] = wd[23:16];
    @(posedge clk); #1;
    m_req = 2'b00;
    n_cmp++;
    if (m_rvalid !== 2'b11 || m_err !== 2'b00 || m_rdata !== {exp_f, 32'h0}) begin
      n_err++; $display("FAIL par_rsp: rvalid %b err %b rdata %h want 11/00/%h00000000",
                        m_rvalid, m_err, m_rdata, exp_f);
    end
    // Read the written word back to see the masked merge.
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    @(posedge clk); #1;
    m_req = 2'b00;
    n_cmp++;
    if (m_rvalid !== 2'b01 || m_rdata[31:0] !== ref_mem[0]) begin
      n_err++; $display("FAIL par_readback: rvalid %b rdata %h want 01/%h", m_rvalid,
                        m_rdata[31:0], ref_mem[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g [4];
    logic [1:0] prev;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    prev = 2'b00;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        set_req(0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0);
      end else begin
        m_req = 2'b00;
      end
      if (i > 0) begin
        n_cmp++;
        if (m_rvalid !== prev ||
            (prev[0] && m_rdata[31:0] !== ref_mem[2]) ||
            (prev[1] && m_rdata[63:32] !== ref_mem[6])) begin
          n_err++; $display("FAIL conflict_rsp[%0d]: rvalid %b rdata %h want %b/%h_%h", i,
                            m_rvalid, m_rdata, prev, ref_mem[6], ref_mem[2]);
        end
      end
      if (i < 4) begin
        #4;
        n_cmp++;
        if (m_gnt !== exp_g[i]) begin
          n_err++; $display("FAIL conflict_gnt[%0d]: got %b want %b", i, m_gnt, exp_g[i]);
        end
        prev = exp_g[i];
        mprio[2] = ~mprio[2];
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_out_of_range();
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    set_req(1, 1'b1, 1'b1, 4'hF, 32'h8000_0004, 32'hDEAD_BEEF);
    #4;
    n_cmp++;
    if (m_gnt !== 2'b11 || csb !== 4'hF) begin
      n_err++; $display("FAIL oor_gnt: gnt %b csb %b want 11/1111", m_gnt, csb);
    end
    @(posedge clk); #1;
    m_req = 2'b00;
    n_cmp++;
    if (m_rvalid !== 2'b11 || m_err !== 2'b11 || m_rdata !== 64'h0) begin
      n_err++; $display("FAIL oor_rsp: rvalid %b err %b rdata %h want 11/11/0", m_rvalid, m_err,
                        m_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) set_req(0, 1'b1, 1'b0, 4'hF, 32'(4 * i), 32'h0);
      else m_req = 2'b00;
      if (i > 0) begin
        n_cmp++;
        if (m_rvalid !== 2'b01 || m_rdata[31:0] !== ref_mem[i-1]) begin
          n_err++; $display("FAIL b2b_rsp[%0d]: rvalid %b rdata %h want 01/%h", i - 1, m_rvalid,
                            m_rdata[31:0], ref_mem[i-1]);
        end
      end
      if (i < 8) begin
        #4;
        n_cmp++;
        if (m_gnt !== 2'b01) begin
          n_err++; $display("FAIL b2b_gnt[%0d]: got %b want 01", i, m_gnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0);
    #4;
    n_cmp++;
    if (m_gnt !== 2'b01) begin n_err++; $display("FAIL rmid_gnt: got %b want 01", m_gnt); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (m_rvalid !== 2'b00 || csb !== 4'hF || m_gnt !== 2'b00) begin
      n_err++; $display("FAIL rmid_flush: rvalid %b csb %b gnt %b want 00/1111/00", m_rvalid,
                        csb, m_gnt);
    end
    reset = 1'b0;
    for (int b = 0; b < NB; b++) mprio[b] = 1'b0;
    #1;
    // Without the reset, the fabric would win this tie.
    n_cmp++;
    if (m_gnt !== 2'b01) begin n_err++; $display("FAIL rmid_prio: got %b want 01", m_gnt); end
    m_req = 2'b00;
    @(posedge clk); #1;
    n_cmp++;
    if (m_rvalid !== 2'b00) begin n_err++; $display("FAIL rmid_rsp: got %b want 00", m_rvalid); end
  endtask

  task automatic test_random(input int unsigned ncyc);
    logic [1:0]  held, req, g, exp_rv, exp_err;
    logic [31:0] a [2];
    logic [31:0] wd [2];
    logic [31:0] exp_rd [2];
    logic [3:0]  be [2];
    logic        w [2];
    logic        oor [2];
    logic        contend;
    int unsigned bk [2];
    int unsigned wi [2];
    held = 2'b00; req = 2'b00; exp_rv = 2'b00; exp_err = 2'b00;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    for (int m = 0; m < 2; m++) begin
      a[m] = 32'h0; wd[m] = 32'h0; be[m] = 4'h0; w[m] = 1'b0;
    end
    for (int unsigned c = 0; c <= ncyc; c++) begin
      n_cmp++;
      if (m_rvalid !== exp_rv) begin
        n_err++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, m_rvalid, exp_rv);
      end
      for (int m = 0; m < 2; m++) begin
        if (exp_rv[m]) begin
          n_cmp++;
          if (m_err[m] !== exp_err[m] || m_rdata[32*m +: 32] !== exp_rd[m]) begin
            n_err++; $display("FAIL rnd_rsp[%0d] m%0d: err %b rdata %h want %b/%h", c, m,
                              m_err[m], m_rdata[32*m +: 32], exp_err[m], exp_rd[m]);
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (c == ncyc) begin
          req[m] = 1'b0;
        end else if (!held[m]) begin
          req[m] = ($urandom_range(0, 3) != 0);
          w[m]   = 1'($urandom_range(0, 1));
          be[m]  = 4'($urandom_range(0, 15));
          wd[m]  = $urandom;
          case ($urandom_range(0, 7))
            0:       a[m] = 32'h1000 | $urandom;
            1:       a[m] = $urandom_range(0, ByteSpan - 1);
            default: a[m] = $urandom_range(0, 63);
          endcase
        end
        set_req(m, req[m], w[m], be[m], a[m], wd[m]);
      end
      #4;
      for (int m = 0; m < 2; m++) begin
        oor[m] = a[m] >= ByteSpan;
        wi[m]  = (a[m] / 4) % Words;
        bk[m]  = wi[m] % NB;
      end
      contend = req[0] && req[1] && !oor[0] && !oor[1] && (bk[0] == bk[1]);
      for (int m = 0; m < 2; m++) begin
        g[m] = req[m] && (!contend || (mprio[bk[m]] == (m == 1)));
      end
      if (contend) mprio[bk[0]] = ~mprio[bk[0]];
      n_cmp++;
      if (m_gnt !== g) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, m_gnt, g); end
      for (int m = 0; m < 2; m++) begin
        exp_rv[m]  = g[m];
        exp_err[m] = oor[m];
        exp_rd[m]  = (g[m] && !w[m] && !oor[m]) ? ref_mem[wi[m]] : 32'h0;
      end
      for (int m = 0; m < 2; m++) begin
        if (g[m] && w[m] && !oor[m]) begin
          for (int k = 0; k < 4; k++) if (be[m][k]) ref_mem[wi[m]][8*k +: 8] = wd[m][8*k +: 8];
        end
        held[m] = req[m] & ~g[m];
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    m_req   = 2'b00;
    m_we    = 2'b00;
    m_be    = 8'h00;
    m_addr  = 64'h0;
    m_wdata = 64'h0;
    for (int unsigned wv = 0; wv < Words; wv++) begin
      ref_mem[wv] = seed_word(wv);
      sram_mem[wv % NB][wv / NB] = seed_word(wv);
    end
    for (int b = 0; b < NB; b++) mprio[b] = 1'b0;
    test_reset();
    test_single_read();
    test_parallel();
    test_conflict();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
